// File: rtl/c16_snd_pkg.sv
// Shared constants and types for the c16 square/noise sound generator.
package c16_snd_pkg;

  localparam logic [1:0] P_PERIOD = 2'd0;
  localparam logic [1:0] P_VOL    = 2'd1;
  localparam logic [1:0] P_DUTY   = 2'd2;
  localparam logic [1:0] P_CTRL   = 2'd3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_NOISE = 1;
  localparam int unsigned CTRL_PRST = 2;

  localparam logic [14:0] LFSR_SEED  = 15'h0001;
  localparam int unsigned LFSR_TAP_A = 14;
  localparam int unsigned LFSR_TAP_B = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } mix_state_e;

  // Clamp a widened mixer value into the signed 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/c16_snd_channel.sv
// One sound channel: CPU-written registers, phase accumulator, noise LFSR and
// the signed contribution the mixer sums.
module c16_snd_channel
  import c16_snd_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick,
  input  logic              wen,
  input  logic [1:0]        w_param,
  input  logic [15:0]       w_val,
  output logic signed [7:0] contrib
);

  logic [15:0] period_q, period_d;
  logic [6:0]  vol_q, vol_d;
  logic [15:0] duty_q, duty_d;
  logic        en_q, en_d;
  logic        noise_q, noise_d;
  logic [15:0] phase_q, phase_d;
  logic [14:0] lfsr_q, lfsr_d;

  logic        active;
  logic        wrap;
  logic        level;
  logic [7:0]  vol_ext;

  always_comb begin
    period_d = period_q;
    vol_d    = vol_q;
    duty_d   = duty_q;
    en_d     = en_q;
    noise_d  = noise_q;
    phase_d  = phase_q;
    lfsr_d   = lfsr_q;

    active = en_q && (period_q != 16'd0);
    // Also catches a period rewritten below the current phase.
    wrap   = phase_q >= (period_q - 16'd1);

    // Advance uses the registered (pre-write) period/enable.
    if (tick && active) begin
      if (wrap) begin
        phase_d = 16'd0;
        lfsr_d  = {lfsr_q[13:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
      end else begin
        phase_d = phase_q + 16'd1;
      end
    end

    if (wen) begin
      unique case (w_param)
        P_PERIOD: period_d = w_val;
        P_VOL:    vol_d    = w_val[6:0];
        P_DUTY:   duty_d   = w_val;
        P_CTRL: begin
          en_d    = w_val[CTRL_EN];
          noise_d = w_val[CTRL_NOISE];
          if (w_val[CTRL_PRST]) begin
            phase_d = 16'd0;
          end
        end
      endcase
    end
  end

  always_comb begin
    level   = noise_q ? lfsr_q[0] : (phase_q < duty_q);
    vol_ext = {1'b0, vol_q};
    if (!active) begin
      contrib = 8'sd0;
    end else if (level) begin
      contrib = vol_ext;
    end else begin
      contrib = -vol_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_q <= 16'd0;
      vol_q    <= 7'd0;
      duty_q   <= 16'd0;
      en_q     <= 1'b0;
      noise_q  <= 1'b0;
      phase_q  <= 16'd0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      period_q <= period_d;
      vol_q    <= vol_d;
      duty_q   <= duty_d;
      en_q     <= en_d;
      noise_q  <= noise_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
    end
  end

endmodule

// File: rtl/c16_sound.sv
// c16 sound generator top: CPU write decode, sample-rate divider and a
// sequential mixer that sums one channel per cycle into a saturated sample.
module c16_sound
  import c16_snd_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        snd_wen,
  input  logic [1:0]  w_param,
  input  logic [10:0] w_index,
  input  logic [15:0] w_val,
  output logic [15:0] sample_out,
  output logic        sample_valid
);

  localparam int unsigned ACC_W = (NUM_CH > 4) ? $clog2(127 * NUM_CH) + 2 : 10;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  logic [DIV_W-1:0]        div_q, div_d;
  logic                    tick;
  mix_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             out_q, out_d;
  logic                    valid_q, valid_d;

  logic                    w_in_range;
  logic [NUM_CH-1:0]       ch_wen;
  logic signed [7:0]       contrib [NUM_CH];
  logic signed [7:0]       contrib_sel;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [31:0]      acc_shift;

  assign w_in_range = 32'(w_index) < NUM_CH;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wen[i] = snd_wen && w_in_range && (w_index == 11'(i));

    c16_snd_channel u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .tick    (tick),
      .wen     (ch_wen[i]),
      .w_param (w_param),
      .w_val   (w_val),
      .contrib (contrib[i])
    );
  end

  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = 1'b0;

    // Live contribution: writes landing mid-pass affect channels not yet summed.
    contrib_sel = contrib[idx_q];
    acc_sum     = acc_q + {{(ACC_W - 8){contrib_sel[7]}}, contrib_sel};
    acc_shift   = {{(32 - ACC_W){acc_sum[ACC_W-1]}}, acc_sum} <<< 6;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = MIX;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      MIX: begin
        acc_d = acc_sum;
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          // Outputs are registered so they are presented while in DONE.
          state_d = DONE;
          out_d   = sat16(acc_shift);
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q   <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;

endmodule
